dfp_line_adapter: RTL and testbench



---
 rtl/dfp_line_adapter_if.sv | 34 +++
 rtl/dfp_line_adapter.sv | 93 +++++++++
 tb/tb_dfp_line_adapter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/dfp_line_adapter_if.sv
// dfp_line_adapter_if: DFP line port plus burst-memory port of one cache-side memory adapter
// Ports (grouped signals):
//   dfp_addr/dfp_read/dfp_write/dfp_wdata    line request from the dcache controller
//   dfp_rdata/dfp_resp                        fetched line and one-cycle completion pulse
//   bmem_addr/bmem_read/bmem_write/bmem_wdata burst command and write beats to memory
//   bmem_ready/bmem_rdata/bmem_rvalid         memory accept strobe and read beats
// slave is the adapter's view; master is the view of the dcache plus memory around it.
interface dfp_line_adapter_if #(
  parameter int LINE_WIDTH = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] dfp_addr;
  logic dfp_read;
  logic dfp_write;
  logic [LINE_WIDTH-1:0] dfp_wdata;
  logic [LINE_WIDTH-1:0] dfp_rdata;
  logic dfp_resp;
  logic [ADDR_WIDTH-1:0] bmem_addr;
  logic bmem_read;
  logic bmem_write;
  logic [BURST_WIDTH-1:0] bmem_wdata;
  logic bmem_ready;
  logic [BURST_WIDTH-1:0] bmem_rdata;
  logic bmem_rvalid;
  modport slave (
    input dfp_addr, dfp_read, dfp_write, dfp_wdata, bmem_ready, bmem_rdata, bmem_rvalid,
    output dfp_rdata, dfp_resp, bmem_addr, bmem_read, bmem_write, bmem_wdata
  );
  modport master (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata, bmem_ready, bmem_rdata, bmem_rvalid,
    input dfp_rdata, dfp_resp, bmem_addr, bmem_read, bmem_write, bmem_wdata
  );
endinterface

// File: rtl/dfp_line_adapter.sv
// dfp_line_adapter: serves dcache full-line reads/writebacks as BEATS-beat bursts to burst memory
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   bus       dfp_line_adapter_if.slave: dfp_* line port (in: addr/read/write/wdata, out: rdata/resp)
//             and bmem_* burst port (out: addr/read/write/wdata, in: ready/rdata/rvalid)
// All outputs are registers; dfp_rdata only updates when a read burst completes.
module dfp_line_adapter #(
  parameter int LINE_WIDTH = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  dfp_line_adapter_if.slave bus
);
  localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] AMASK = ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, RESP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [LINE_WIDTH-1:0] line;
  logic [LINE_WIDTH-1:0] filled;
  assign cnt_n = cnt + 1'b1;
  // Line buffer with the current read beat merged in, so the last beat can go straight to dfp_rdata.
  always_comb begin
    filled = line;
    filled[cnt*BURST_WIDTH +: BURST_WIDTH] = bus.bmem_rdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      line <= '0;
      bus.dfp_rdata <= '0;
      bus.dfp_resp <= 1'b0;
      bus.bmem_addr <= '0;
      bus.bmem_read <= 1'b0;
      bus.bmem_write <= 1'b0;
      bus.bmem_wdata <= '0;
    end else begin
      bus.dfp_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.dfp_write) begin
            state <= WR_DATA;
            cnt <= '0;
            line <= bus.dfp_wdata;
            bus.bmem_addr <= bus.dfp_addr & AMASK;
            bus.bmem_write <= 1'b1;
            bus.bmem_wdata <= bus.dfp_wdata[BURST_WIDTH-1:0];
          end else if (bus.dfp_read) begin
            state <= RD_REQ;
            cnt <= '0;
            bus.bmem_addr <= bus.dfp_addr & AMASK;
            bus.bmem_read <= 1'b1;
          end
        end
        RD_REQ: begin
          if (bus.bmem_ready) begin
            state <= RD_DATA;
            bus.bmem_read <= 1'b0;
          end
        end
        RD_DATA: begin
          if (bus.bmem_rvalid) begin
            line <= filled;
            cnt <= cnt_n;
            if (cnt == LAST) begin
              state <= RESP;
              bus.dfp_resp <= 1'b1;
              bus.dfp_rdata <= filled;
            end
          end
        end
        WR_DATA: begin
          if (bus.bmem_ready) begin
            cnt <= cnt_n;
            bus.bmem_wdata <= line[cnt_n*BURST_WIDTH +: BURST_WIDTH];
            if (cnt == LAST) begin
              state <= RESP;
              bus.bmem_write <= 1'b0;
              bus.dfp_resp <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dfp_line_adapter.sv
// tb_dfp_line_adapter: table-driven, directed and randomized checks of dfp_line_adapter
module tb_dfp_line_adapter;
  localparam int LW = 256;
  localparam int BW = 64;
  localparam int AW = 32;
  typedef struct {
    logic rd;
    logic wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wl;
    logic [LW-1:0] rl;
    logic [63:0] rm;
    logic [63:0] vm;
    int gap;
    int resp;
    logic [AW-1:0] baddr;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [LW-1:0] exp_rd = '0;
  int r_resp, r_pulses, r_first, r_overlap, r_hold_bad, r_idle_bad;
  logic [AW-1:0] r_baddr;
  logic [LW-1:0] r_wline;
  vec_t tv[8];
  always #5 clk = ~clk;
  dfp_line_adapter_if #(.LINE_WIDTH(LW), .BURST_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();
  dfp_line_adapter #(.LINE_WIDTH(LW), .BURST_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // Reference timing: a write finishes one cycle after its 4th accepted beat (cycles >= 1);
  // a read's command is taken at the first ready cycle >= 1, then the 4th later rvalid ends it.
  function automatic int model_resp(input logic wr, input logic [63:0] rm, input logic [63:0] vm);
    int n = 0;
    int acc = -1;
    for (int c = 1; c < 64; c++) begin
      if (wr) begin
        if (rm[c]) begin
          n++;
          if (n == 4) return c + 1;
        end
      end else if (acc < 0) begin
        if (rm[c]) acc = c;
      end else if (vm[c]) begin
        n++;
        if (n == 4) return c + 1;
      end
    end
    return -1;
  endfunction
  // Drives one request from cycle 0 until dfp_resp (held through the response cycle), acting as
  // the memory: read beats are served in order on rvalid cycles after the command was accepted.
  // Then gap idle cycles with random stray memory activity.
  task automatic run_txn(input logic rd, input logic wr, input logic [AW-1:0] addr,
                         input logic [LW-1:0] wl, input logic [LW-1:0] rl,
                         input logic [63:0] rm, input logic [63:0] vm, input int gap);
    int acc = -1;
    int k = 0;
    int wb = 0;
    bit done = 0;
    r_resp = -1; r_pulses = 0; r_first = -1; r_overlap = 0; r_hold_bad = 0; r_idle_bad = 0;
    r_baddr = '0; r_wline = '0;
    for (int c = 1; c < 64; c++) if (acc < 0 && rm[c]) acc = c;
    for (int c = 0; c < 64 && !done; c++) begin
      bus.dfp_read = rd;
      bus.dfp_write = wr;
      bus.dfp_addr = c == 0 ? addr : $urandom;
      bus.dfp_wdata = c == 0 ? wl : {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      bus.bmem_ready = rm[c];
      bus.bmem_rvalid = vm[c];
      if (vm[c] && !wr && acc >= 0 && c > acc && k < 4) begin
        bus.bmem_rdata = rl[k*BW +: BW];
        k++;
      end else bus.bmem_rdata = {$urandom, $urandom};
      @(negedge clk);
      if (bus.bmem_read && bus.bmem_write) r_overlap = 1;
      if ((bus.bmem_read || bus.bmem_write) && r_first < 0) begin
        r_first = c;
        r_baddr = bus.bmem_addr;
      end
      if (bus.bmem_write && wb < 4) begin
        if (rm[c]) begin
          r_wline[wb*BW +: BW] = bus.bmem_wdata;
          wb++;
        end else if (bus.bmem_wdata !== wl[wb*BW +: BW]) r_hold_bad = 1;
      end
      if (bus.dfp_resp) begin
        r_resp = c;
        r_pulses++;
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    for (int t = 0; t < gap; t++) begin
      bus.dfp_read = 1'b0;
      bus.dfp_write = 1'b0;
      bus.bmem_ready = 1'($urandom_range(0, 1));
      bus.bmem_rvalid = 1'($urandom_range(0, 1));
      bus.bmem_rdata = {$urandom, $urandom};
      @(negedge clk);
      if (bus.dfp_resp) r_pulses++;
      if (bus.bmem_read || bus.bmem_write) r_idle_bad = 1;
      @(posedge clk);
      #1;
    end
  endtask
  task automatic run_check(input string name, input logic rd, input logic wr, input logic [AW-1:0] addr,
                           input logic [LW-1:0] wl, input logic [LW-1:0] rl,
                           input logic [63:0] rm, input logic [63:0] vm, input int gap,
                           input int exp_resp, input logic [AW-1:0] exp_baddr);
    run_txn(rd, wr, addr, wl, rl, rm, vm, gap);
    if (rd && !wr) exp_rd = rl;
    chk_i({name, " resp_cycle"}, r_resp, exp_resp);
    chk_i({name, " resp_pulses"}, r_pulses, 1);
    chk_i({name, " cmd_cycle"}, r_first, 1);
    chk({name, " bmem_addr"}, LW'(r_baddr), LW'(exp_baddr));
    chk_i({name, " rd_wr_overlap"}, r_overlap, 0);
    chk({name, " dfp_rdata"}, bus.dfp_rdata, exp_rd);
    if (wr) begin
      chk({name, " write_beats"}, r_wline, wl);
      chk_i({name, " wdata_hold"}, r_hold_bad, 0);
    end
    if (gap > 0) chk_i({name, " idle_quiet"}, r_idle_bad, 0);
  endtask
  initial begin
    logic rd, wr;
    logic [AW-1:0] a;
    logic [LW-1:0] wl, rl;
    logic [63:0] rm, vm;
    int op, n;
    tv[0] = '{1'b1, 1'b0, 32'h0000_1234, 256'h0,
              {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
              64'hFFFF_FFFF_FFFF_FFFF, 64'h3C, 2, 6, 32'h0000_1220};
    tv[1] = '{1'b0, 1'b1, 32'h8000_0040,
              {64'hD0D1_D2D3_D4D5_D6D7, 64'hC0C1_C2C3_C4C5_C6C7, 64'hB0B1_B2B3_B4B5_B6B7, 64'hA0A1_A2A3_A4A5_A6A7},
              256'h0, ~64'hC, 64'h0, 2, 7, 32'h8000_0040};
    tv[2] = '{1'b1, 1'b1, 32'h0000_0117, {4{64'h0123_4567_89AB_CDEF}}, {4{64'hDEAD_BEEF_DEAD_BEEF}},
              64'hFFFF_FFFF_FFFF_FFFF, 64'h3E, 2, 5, 32'h0000_0100};
    tv[3] = '{1'b1, 1'b0, 32'h1234_567F, 256'h0,
              {64'h0DDD_0000_0000_0004, 64'h0CCC_0000_0000_0003, 64'h0BBB_0000_0000_0002, 64'h0AAA_0000_0000_0001},
              64'hFFFF_FFFF_FFFF_FFFF, 64'h4C8, 1, 11, 32'h1234_5660};
    tv[4] = '{1'b0, 1'b1, 32'h0000_0000, {64'h8, 64'h4, 64'h2, 64'h1}, 256'h0,
              64'hFFFF_FFFF_FFFF_FFFF, 64'hFF, 2, 5, 32'h0000_0000};
    tv[5] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 256'h0, {4{64'h5A5A_A5A5_0F0F_F0F0}},
              ~64'h6, 64'hF4, 2, 8, 32'hFFFF_FFE0};
    tv[6] = '{1'b0, 1'b1, 32'h0000_2008, {4{64'hFEED_FACE_CAFE_F00D}}, 256'h0,
              64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, 5, 32'h0000_2000};
    tv[7] = '{1'b1, 1'b0, 32'h0000_2010, 256'h0, {64'h7, 64'h6, 64'h5, 64'h4},
              64'hFFFF_FFFF_FFFF_FFFF, 64'h3C, 2, 6, 32'h0000_2000};
    bus.dfp_addr = '0; bus.dfp_read = 1'b0; bus.dfp_write = 1'b0; bus.dfp_wdata = '0;
    bus.bmem_ready = 1'b0; bus.bmem_rdata = '0; bus.bmem_rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset dfp_resp", LW'(bus.dfp_resp), '0);
    chk("reset bmem_read", LW'(bus.bmem_read), '0);
    chk("reset bmem_write", LW'(bus.bmem_write), '0);
    chk("reset dfp_rdata", bus.dfp_rdata, '0);
    chk("reset bmem_addr", LW'(bus.bmem_addr), '0);
    chk("reset bmem_wdata", LW'(bus.bmem_wdata), '0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++)
      run_check($sformatf("vec%0d", i), tv[i].rd, tv[i].wr, tv[i].addr, tv[i].wl, tv[i].rl,
                tv[i].rm, tv[i].vm, tv[i].gap, tv[i].resp, tv[i].baddr);
    // Reset lands in the cycle of read beat 2; the burst must vanish without a response.
    for (int c = 0; c < 5; c++) begin
      bus.dfp_read = 1'b1;
      bus.dfp_addr = 32'h0000_0040;
      bus.bmem_ready = 1'b1;
      bus.bmem_rvalid = c >= 2;
      bus.bmem_rdata = {$urandom, $urandom};
      rst = c == 4;
      @(posedge clk);
      #1;
    end
    chk("midrst dfp_resp", LW'(bus.dfp_resp), '0);
    chk("midrst bmem_read", LW'(bus.bmem_read), '0);
    chk("midrst bmem_write", LW'(bus.bmem_write), '0);
    chk("midrst dfp_rdata", bus.dfp_rdata, '0);
    chk("midrst bmem_addr", LW'(bus.bmem_addr), '0);
    chk("midrst bmem_wdata", LW'(bus.bmem_wdata), '0);
    exp_rd = '0;
    rst = 1'b0;
    bus.dfp_read = 1'b0;
    n = 0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if (bus.dfp_resp) n++;
      @(posedge clk);
      #1;
    end
    chk_i("midrst no_resp", n, 0);
    run_check("after_rst", 1'b1, 1'b0, 32'h0000_0040, '0, {4{64'h1357_9BDF_2468_ACE0}},
              64'hFFFF_FFFF_FFFF_FFFF, 64'h3C, 2, 6, 32'h0000_0040);
    for (int i = 0; i < 20; i++) begin
      op = $urandom_range(0, 2);
      rd = op != 1;
      wr = op != 0;
      a = $urandom;
      for (int j = 0; j < 8; j++) begin
        wl[j*32 +: 32] = $urandom;
        rl[j*32 +: 32] = $urandom;
      end
      rm = {$urandom, $urandom} | 64'hFFFF_FF00_0000_0000;
      vm = {$urandom, $urandom} | 64'hFFFF_FF00_0000_0000;
      run_check($sformatf("rnd%0d", i), rd, wr, a, wl, rl, rm, vm, $urandom_range(0, 2),
                model_resp(wr, rm, vm), a & 32'hFFFF_FFE0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
